// File: rtl/uart_rx16.sv
// ============================================================================
// uart_rx16 : 16x-oversampled 8N1 UART receiver with a one-byte holding register
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx16 #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] ubrr,
    input  logic        rxd,
    input  logic        rd,
    output logic [7:0]  data_o,
    output logic        valid,
    output logic        frame_err,
    output logic        overrun,
    output logic        busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [3:0] c_SAMP_A   = 4'd7;
    localparam logic [3:0] c_SAMP_B   = 4'd8;
    localparam logic [3:0] c_SAMP_MID = 4'd9;
    localparam logic [3:0] c_SAMP_END = 4'd15;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rxd;

    logic [11:0] r_baud;
    logic        w_tick;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [3:0]  r_samp;
    logic [2:0]  r_bit;
    logic        r_s7;
    logic        r_s8;
    logic        w_maj;
    logic [7:0]  r_shift;

    logic        w_busy;
    logic        w_take_bit;
    logic        w_done;

    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_ferr;
    logic        r_ovr;

    // Synchronizer resets to the idle level so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rxd};
        end
    end

    assign w_rxd = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_baud <= 12'd0;
        end else if (w_tick) begin
            r_baud <= ubrr;
        end else begin
            r_baud <= r_baud - 12'd1;
        end
    end

    assign w_tick = (r_baud == 12'd0);

    // Majority vote of the three centre samples; the third is the live sample at count 9
    assign w_maj = (r_s7 & r_s8) | (r_s7 & w_rxd) | (r_s8 & w_rxd);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_tick && !w_rxd) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_tick && (r_samp == c_SAMP_MID) && w_maj) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tick && (r_samp == c_SAMP_END)) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick && (r_samp == c_SAMP_END) && (r_bit == 3'd7)) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_tick && (r_samp == c_SAMP_MID)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy     = (r_state != S_IDLE);
        w_take_bit = w_tick && (r_state == S_DATA) && (r_samp == c_SAMP_MID);
        w_done     = w_tick && (r_state == S_STOP) && (r_samp == c_SAMP_MID);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_samp  <= 4'd0;
            r_bit   <= 3'd0;
            r_s7    <= 1'b1;
            r_s8    <= 1'b1;
            r_shift <= 8'h00;
        end else if (w_tick) begin
            if (r_samp == c_SAMP_A) begin
                r_s7 <= w_rxd;
            end
            if (r_samp == c_SAMP_B) begin
                r_s8 <= w_rxd;
            end
            // The detecting tick counts as sample 0 of the start bit
            if (w_state_nxt == S_IDLE) begin
                r_samp <= 4'd0;
            end else if (r_state == S_IDLE) begin
                r_samp <= 4'd1;
            end else begin
                r_samp <= r_samp + 4'd1;
            end
            if (r_state == S_START) begin
                r_bit <= 3'd0;
            end else if ((r_state == S_DATA) && (r_samp == c_SAMP_END)) begin
                r_bit <= r_bit + 3'd1;
            end
            if (w_take_bit) begin
                r_shift <= {w_maj, r_shift[7:1]};
            end
        end
    end

    // A read in the completion cycle frees the register for the new byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else if (w_done) begin
            if (!r_valid || rd) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
                r_ferr  <= ~w_maj;
                r_ovr   <= 1'b0;
            end else begin
                r_ovr   <= 1'b1;
            end
        end else if (rd && r_valid) begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end
    end

    assign data_o    = r_data;
    assign valid     = r_valid;
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;
    assign busy      = w_busy;

endmodule

`default_nettype wire
